// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO controllers: Gray/binary
// conversion helpers, default synchroniser depth and drop-counter width.
package async_fifo_pkg;

  localparam int unsigned SyncStagesDefault = 2;
  localparam int unsigned DropCntWidth      = 8;

  // Binary to Gray; callers zero-extend narrower pointers and truncate the result.
  function automatic logic [31:0] bin2gray(logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary via an XOR prefix running down from the MSB.
  function automatic logic [31:0] gray2bin(logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the asynchronous FIFO: client handshake, RAM write port,
// status and the Gray pointers exchanged with the read domain.
interface async_fifo_wr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  import async_fifo_pkg::*;

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic                    winc;
  logic [PW-1:0]           rptr_gray;
  logic                    wen;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [PW-1:0]           wptr_gray;
  logic                    wfull;
  logic                    walmost_full;
  logic [PW-1:0]           wlevel;
  logic                    wovf;
  logic [DropCntWidth-1:0] wdrop_cnt;

  // Client / environment side.
  modport master (
    output winc, rptr_gray,
    input  wen, waddr, wptr_gray, wfull, walmost_full, wlevel, wovf, wdrop_cnt
  );

  // Controller side.
  modport slave (
    input  winc, rptr_gray,
    output wen, waddr, wptr_gray, wfull, walmost_full, wlevel, wovf, wdrop_cnt
  );

endinterface

// File: rtl/async_fifo_sync.sv
// Multi-flop synchroniser for a Gray-coded bus; the last stage is the output.
module async_fifo_sync #(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  // Shift chain with synchronous active-high clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Stages); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(Stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO. Owns the binary/Gray write
// pointer, synchronises the read Gray pointer and produces registered full,
// almost-full and level status. Status is pessimistic by the sync latency.
// Optional overflow monitor enabled by defining ASYNC_FIFO_WR_OVF_EN.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned SYNC_STAGES  = SyncStagesDefault,
  parameter int unsigned AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  async_fifo_wr_ctrl_if.slave  bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic [PW-1:0] wq_rptr_gray;
  logic [PW-1:0] wq_rptr_bin;
  logic          wen;

  async_fifo_sync #(
    .Width  (PW),
    .Stages (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i (wclk),
    .rst_i (wrst),
    .d_i   (bus.rptr_gray),
    .q_o   (wq_rptr_gray)
  );

  assign wq_rptr_bin = PW'(gray2bin(32'(wq_rptr_gray)));
  assign wen         = bus.winc & ~wfull_q;

  // Next pointer and status; write and read movement fold into one computation.
  always_comb begin
    wbin_d   = wbin_q + PW'(wen);
    wgray_d  = PW'(bin2gray(32'(wbin_d)));
    wlevel_d = wbin_d - wq_rptr_bin;
    // Full: write pointer one lap ahead, i.e. top two Gray bits inverted.
    wfull_d  = (wgray_d == {~wq_rptr_gray[PW-1:PW-2], wq_rptr_gray[PW-3:0]});
    wafull_d = (32'(wlevel_d) >= AFULL_THRESH);
  end

  // Pointer and status registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

  assign bus.wen          = wen;
  assign bus.waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr_gray    = wgray_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wlevel       = wlevel_q;

`ifdef ASYNC_FIFO_WR_OVF_EN
  logic                    wovf_q;
  logic [DropCntWidth-1:0] wdrop_q;

  // Sticky overflow flag and saturating count of rejected writes.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf_q  <= 1'b0;
      wdrop_q <= '0;
    end else if (bus.winc && wfull_q) begin
      wovf_q <= 1'b1;
      if (wdrop_q != '1) begin
        wdrop_q <= wdrop_q + 1'b1;
      end
    end
  end

  assign bus.wovf      = wovf_q;
  assign bus.wdrop_cnt = wdrop_q;
`else
  assign bus.wovf      = 1'b0;
  assign bus.wdrop_cnt = '0;
`endif

endmodule
